// File: rtl/segre_pkg.sv
// Shared Segre types: ALU/branch opcodes, BHT counter type
// and the branch resolution bundle.
package segre_pkg;

    localparam int WORD_SIZE           = 32;
    localparam int BHT_ENTRIES_DEFAULT = 64;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_BEQ,
        ALU_BNE,
        ALU_BLT,
        ALU_BGE,
        ALU_BLTU,
        ALU_BGEU,
        ALU_JAL,
        ALU_JALR
    } alu_opcode_e;

    typedef logic [1:0] bht_ctr_t;

    typedef struct packed {
        logic                 taken;
        logic [WORD_SIZE-1:0] next_pc;
        logic                 mispred;
    } br_result_t;

endpackage

// File: rtl/segre_bht.sv
// Bimodal branch-history table: 2-bit saturating counters,
// one training write port and one combinational read port.
module segre_bht
    import segre_pkg::*;
#(
    parameter int ENTRIES = BHT_ENTRIES_DEFAULT,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rsn_i,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o
);

    bht_ctr_t ctr_q [ENTRIES];
    bht_ctr_t cur;
    bht_ctr_t ctr_d;

    assign cur = ctr_q[upd_idx_i];

    always_comb begin
        ctr_d = cur;
        if (upd_taken_i) begin
            if (cur != 2'b11) ctr_d = cur + 2'b01;
        end else begin
            if (cur != 2'b00) ctr_d = cur - 2'b01;
        end
    end

    // Counters come out of reset weakly not-taken.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
        end else if (upd_en_i) begin
            ctr_q[upd_idx_i] <= ctr_d;
        end
    end

    assign rd_taken_o = ctr_q[rd_idx_i][1];

endmodule

// File: rtl/segre_br_unit.sv
// Segre branch resolution: condition/target evaluation, mispredict
// redirect handshake, BHT training and performance counters.
module segre_br_unit
    import segre_pkg::*;
#(
    parameter int WIDTH       = WORD_SIZE,
    parameter int BHT_ENTRIES = BHT_ENTRIES_DEFAULT,
    parameter int IDX_LSB     = 2
) (
    input  logic             clk_i,
    input  logic             rsn_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  alu_opcode_e      alu_opcode_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [WIDTH-1:0] br_src_a_i,
    input  logic [WIDTH-1:0] br_src_b_i,
    input  logic [WIDTH-1:0] imm_i,
    input  logic             pred_taken_i,
    input  logic [WIDTH-1:0] pred_target_i,
    input  logic             flush_i,
    output logic             res_valid_o,
    output logic             tkbr_o,
    output logic [WIDTH-1:0] next_pc_o,
    output logic             redirect_valid_o,
    output logic [WIDTH-1:0] redirect_pc_o,
    input  logic             redirect_ready_i,
    input  logic [WIDTH-1:0] lookup_pc_i,
    output logic             lookup_taken_o,
    output logic [31:0]      br_count_o,
    output logic [31:0]      mispred_count_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic             accept;
    logic             taken;
    logic             is_br;
    logic             is_cond;
    logic [WIDTH-1:0] jalr_sum;
    logic [WIDTH-1:0] target;
    br_result_t       res;

    logic             res_valid_q, res_valid_d;
    logic             tkbr_q, tkbr_d;
    logic [WIDTH-1:0] next_pc_q, next_pc_d;
    logic             rdir_q, rdir_d;
    logic [WIDTH-1:0] rdir_pc_q, rdir_pc_d;
    logic [31:0]      br_cnt_q, br_cnt_d;
    logic [31:0]      mis_cnt_q, mis_cnt_d;

    assign ready_o = !rdir_q;
    assign accept  = valid_i && ready_o && !flush_i;

    always_comb begin
        taken   = 1'b0;
        is_br   = 1'b1;
        is_cond = 1'b1;
        unique case (alu_opcode_i)
            ALU_BEQ:  taken = br_src_a_i == br_src_b_i;
            ALU_BNE:  taken = br_src_a_i != br_src_b_i;
            ALU_BLT:  taken = $signed(br_src_a_i) < $signed(br_src_b_i);
            ALU_BGE:  taken = $signed(br_src_a_i) >= $signed(br_src_b_i);
            ALU_BLTU: taken = br_src_a_i < br_src_b_i;
            ALU_BGEU: taken = br_src_a_i >= br_src_b_i;
            ALU_JAL, ALU_JALR: begin
                taken   = 1'b1;
                is_cond = 1'b0;
            end
            default: begin
                is_br   = 1'b0;
                is_cond = 1'b0;
            end
        endcase
    end

    assign jalr_sum = br_src_a_i + imm_i;
    assign target   = (alu_opcode_i == ALU_JALR)
                    ? {jalr_sum[WIDTH-1:1], 1'b0}
                    : pc_i + imm_i;

    // Non-branch opcodes fall through sequentially and never redirect.
    always_comb begin
        res.taken   = taken;
        res.next_pc = taken ? target : pc_i + WIDTH'(4);
        res.mispred = is_br && ((pred_taken_i != taken) ||
                      (taken && pred_target_i != target));
    end

    always_comb begin
        res_valid_d = accept;
        tkbr_d      = tkbr_q;
        next_pc_d   = next_pc_q;
        rdir_d      = rdir_q;
        rdir_pc_d   = rdir_pc_q;
        br_cnt_d    = br_cnt_q;
        mis_cnt_d   = mis_cnt_q;
        if (accept) begin
            tkbr_d    = res.taken;
            next_pc_d = res.next_pc;
            if (is_br) br_cnt_d = br_cnt_q + 32'd1;
            if (res.mispred) begin
                mis_cnt_d = mis_cnt_q + 32'd1;
                rdir_d    = 1'b1;
                rdir_pc_d = res.next_pc;
            end
        end
        if (rdir_q && redirect_ready_i) rdir_d = 1'b0;
        if (flush_i) rdir_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            res_valid_q <= 1'b0;
            tkbr_q      <= 1'b0;
            next_pc_q   <= '0;
            rdir_q      <= 1'b0;
            rdir_pc_q   <= '0;
            br_cnt_q    <= '0;
            mis_cnt_q   <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            tkbr_q      <= tkbr_d;
            next_pc_q   <= next_pc_d;
            rdir_q      <= rdir_d;
            rdir_pc_q   <= rdir_pc_d;
            br_cnt_q    <= br_cnt_d;
            mis_cnt_q   <= mis_cnt_d;
        end
    end

    segre_bht #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk_i       (clk_i),
        .rsn_i       (rsn_i),
        .upd_en_i    (accept && is_cond),
        .upd_idx_i   (pc_i[IDX_LSB +: IDX_W]),
        .upd_taken_i (taken),
        .rd_idx_i    (lookup_pc_i[IDX_LSB +: IDX_W]),
        .rd_taken_o  (lookup_taken_o)
    );

    assign res_valid_o      = res_valid_q;
    assign tkbr_o           = tkbr_q;
    assign next_pc_o        = next_pc_q;
    assign redirect_valid_o = rdir_q;
    assign redirect_pc_o    = rdir_pc_q;
    assign br_count_o       = br_cnt_q;
    assign mispred_count_o  = mis_cnt_q;

endmodule

// File: tb/tb_segre_br_unit.sv
// Randomised plus directed bench for segre_br_unit against an
// architectural reference model of branch resolution.
module tb_segre_br_unit;
    import segre_pkg::*;

    logic        clk = 1'b0;
    logic        rsn = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    alu_opcode_e op = ALU_ADD;
    logic [31:0] pc = '0, a = '0, b = '0, imm = '0;
    logic        pt = 1'b0;
    logic [31:0] ptgt = '0;
    logic        flush = 1'b0;
    logic        res_valid, tkbr;
    logic [31:0] next_pc;
    logic        rv;
    logic [31:0] rpc;
    logic        rr = 1'b0;
    logic [31:0] lpc = '0;
    logic        ltaken;
    logic [31:0] brc, misc;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    bit          m_res_valid, m_tkbr, m_rv;
    logic [31:0] m_next_pc, m_rpc;
    int unsigned m_br, m_mis;
    int          m_bht [64];

    always #5 clk = ~clk;

    segre_br_unit dut (
        .clk_i            (clk),
        .rsn_i            (rsn),
        .valid_i          (valid),
        .ready_o          (ready),
        .alu_opcode_i     (op),
        .pc_i             (pc),
        .br_src_a_i       (a),
        .br_src_b_i       (b),
        .imm_i            (imm),
        .pred_taken_i     (pt),
        .pred_target_i    (ptgt),
        .flush_i          (flush),
        .res_valid_o      (res_valid),
        .tkbr_o           (tkbr),
        .next_pc_o        (next_pc),
        .redirect_valid_o (rv),
        .redirect_pc_o    (rpc),
        .redirect_ready_i (rr),
        .lookup_pc_i      (lpc),
        .lookup_taken_o   (ltaken),
        .br_count_o       (brc),
        .mispred_count_o  (misc)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_taken(alu_opcode_e o, logic [31:0] x,
                                   logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'd0, x});
        longint uy = longint'({32'd0, y});
        case (o)
            ALU_BEQ:  return ux == uy;
            ALU_BNE:  return ux != uy;
            ALU_BLT:  return sx < sy;
            ALU_BGE:  return sx >= sy;
            ALU_BLTU: return ux < uy;
            ALU_BGEU: return ux >= uy;
            ALU_JAL, ALU_JALR: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_target(alu_opcode_e o,
        logic [31:0] p, logic [31:0] x, logic [31:0] i);
        longint s;
        if (o == ALU_JALR) begin
            s = (longint'({32'd0, x}) + longint'({32'd0, i})) % (64'd1 << 32);
            return 32'(s - (s % 2));
        end
        return 32'((longint'({32'd0, p}) + longint'({32'd0, i})) % (64'd1 << 32));
    endfunction

    function automatic bit is_branch(alu_opcode_e o);
        return o inside {ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE,
                         ALU_BLTU, ALU_BGEU, ALU_JAL, ALU_JALR};
    endfunction

    function automatic int bidx(logic [31:0] p);
        return int'((p / 4) % 64);
    endfunction

    task automatic model_reset();
        m_res_valid = 0; m_tkbr = 0; m_rv = 0;
        m_next_pc = '0; m_rpc = '0; m_br = 0; m_mis = 0;
        foreach (m_bht[i]) m_bht[i] = 1;
    endtask

    task automatic check_all();
        check("res_valid", 32'(res_valid), 32'(m_res_valid));
        check("tkbr", 32'(tkbr), 32'(m_tkbr));
        check("next_pc", next_pc, m_next_pc);
        check("redirect_valid", 32'(rv), 32'(m_rv));
        check("redirect_pc", rpc, m_rpc);
        check("ready", 32'(ready), 32'(!m_rv));
        check("br_count", brc, m_br);
        check("mispred_count", misc, m_mis);
    endtask

    task automatic check_lookup(input logic [31:0] p);
        lpc = p;
        #1;
        check("lookup_taken", 32'(ltaken), 32'(m_bht[bidx(p)] >= 2));
    endtask

    // Advance one clock with current inputs, update model, compare.
    task automatic tick();
        bit acc, tk, mis, br;
        logic [31:0] tgt, npc;
        @(posedge clk);
        acc = valid && !m_rv && !flush;
        br  = is_branch(op);
        tk  = m_taken(op, a, b);
        tgt = m_target(op, pc, a, imm);
        npc = tk ? tgt : 32'((longint'({32'd0, pc}) + 4) % (64'd1 << 32));
        mis = br && (pt != tk || (tk && ptgt != tgt));
        if (flush) m_rv = 0;
        else if (m_rv && rr) m_rv = 0;
        m_res_valid = acc;
        if (acc) begin
            m_tkbr = tk;
            m_next_pc = npc;
            if (br) m_br++;
            if (mis) begin
                m_mis++;
                m_rv = 1;
                m_rpc = npc;
            end
            if (br && op != ALU_JAL && op != ALU_JALR) begin
                if (tk) m_bht[bidx(pc)] = (m_bht[bidx(pc)] == 3) ? 3 : m_bht[bidx(pc)] + 1;
                else    m_bht[bidx(pc)] = (m_bht[bidx(pc)] == 0) ? 0 : m_bht[bidx(pc)] - 1;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input alu_opcode_e o, input logic [31:0] p,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] i, input bit ptk,
                         input logic [31:0] ptg);
        valid = 1; op = o; pc = p; a = x; b = y; imm = i;
        pt = ptk; ptgt = ptg;
    endtask

    task automatic idle();
        valid = 0; op = ALU_ADD; pt = 0; flush = 0;
    endtask

    initial begin
        alu_opcode_e ops [9];
        ops = '{ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
                ALU_BGEU, ALU_JAL, ALU_JALR, ALU_ADD};
        model_reset();
        #12;
        @(negedge clk);
        check_all();
        check_lookup(32'h40);
        rsn = 1'b1;
        @(negedge clk);

        // BLT signed: -1 < 1, predicted not-taken
        drive(ALU_BLT, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 0, 0);
        tick();
        check("blt_tkbr", 32'(tkbr), 32'd1);
        check("blt_npc", next_pc, 32'h120);
        check("blt_rpc", rpc, 32'h120);
        check("blt_mis", misc, 32'd1);
        idle(); rr = 1; tick(); rr = 0; tick();

        // BLTU same operands: not taken
        drive(ALU_BLTU, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 0, 0);
        tick();
        check("bltu_npc", next_pc, 32'h104);
        check("bltu_rv", 32'(rv), 32'd0);

        drive(ALU_JALR, 32'h300, 32'h203, 32'h0, 32'h4, 1, 32'h206);
        tick();
        check("jalr_npc", next_pc, 32'h206);
        check("jalr_rv", 32'(rv), 32'd0);
        drive(ALU_JALR, 32'h300, 32'h203, 32'h0, 32'h4, 1, 32'h208);
        tick();
        check("jalr2_rpc", rpc, 32'h206);
        idle(); rr = 1; tick(); rr = 0;

        // Redirect held while ready is low
        drive(ALU_BNE, 32'h500, 32'h1, 32'h2, 32'h10, 0, 0);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            check("hold_ready", 32'(ready), 32'd0);
            tick();
        end
        rr = 1; tick(); rr = 0;
        check("hold_clear", 32'(rv), 32'd0);
        drive(ALU_BNE, 32'h500, 32'h1, 32'h2, 32'h10, 0, 0);
        tick();
        idle(); tick();
        flush = 1; tick(); flush = 0;
        check("flush_clear", 32'(rv), 32'd0);

        // BHT training at 0x40
        check_lookup(32'h40);
        for (int k = 0; k < 3; k++) begin
            drive(ALU_BEQ, 32'h40, 32'h5, 32'h5, 32'h8, 1, 32'h48);
            tick();
            check_lookup(32'h40);
        end
        for (int k = 0; k < 4; k++) begin
            drive(ALU_BEQ, 32'h40, 32'h5, 32'h6, 32'h8, 0, 0);
            tick();
            check_lookup(32'h40);
        end
        idle(); tick();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            alu_opcode_e o;
            logic [31:0] p, x, y, i, t;
            o = ops[$urandom_range(0, 8)];
            p = {22'd0, 8'($urandom), 2'b00};
            x = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3)) - 32'd1;
            y = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3)) - 32'd1;
            i = 32'($signed(12'($urandom)));
            t = m_target(o, p, x, i);
            if ($urandom_range(0, 1) == 0) t = t + 32'h4;
            drive(o, p, x, y, i, is_branch(o) ? 1'($urandom) : 1'b0, t);
            valid = ($urandom_range(0, 4) != 0);
            flush = ($urandom_range(0, 9) == 0);
            rr = 1'($urandom);
            lpc = {22'd0, 8'($urandom), 2'b00};
            tick();
            check_lookup({22'd0, 8'($urandom), 2'b00});
        end

        // Async reset during a pending redirect
        idle(); rr = 0;
        drive(ALU_BNE, 32'h600, 32'h1, 32'h2, 32'h10, 0, 0);
        tick();
        idle();
        check("pre_reset_rv", 32'(rv), 32'd1);
        #2;
        rsn = 1'b0;
        model_reset();
        #1;
        check_all();
        check_lookup(32'h40);
        check_lookup(32'h1F4);
        #20;
        rsn = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/segre_br_unit.md
# segre_br_unit

Branch resolution unit for the Segre execute stage. Evaluates branch/jump conditions for `alu_opcode_e` branch opcodes, computes the architectural target, compares against the fetch-stage prediction, and raises a held redirect request on misprediction. It also owns a parametrised bimodal branch-history table (2-bit counters) trained at resolution and read combinationally by fetch, plus wrapping branch and mispredict counters.

## Interface
Parameters:
- `WIDTH`, `WORD_SIZE` (32): data/address width.
- `BHT_ENTRIES`, 64: counter count; power of two, ≥ 2.
- `IDX_LSB`, 2: lowest PC bit used for BHT index.

Ports:
- `clk_i` in 1: clock.
- `rsn_i` in 1: reset; asynchronous, active-low.
- `valid_i` in 1: instruction present.
- `ready_o` out 1: unit accepts this cycle.
- `alu_opcode_i` in `alu_opcode_e`: BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR; any other opcode is resolved as not-taken and counted nowhere.
- `pc_i`, `br_src_a_i`, `br_src_b_i`, `imm_i` in WIDTH each: PC, operands, sign-extended immediate.
- `pred_taken_i` in 1, `pred_target_i` in WIDTH: prediction made by fetch.
- `flush_i` in 1: kill from an older instruction.
- `res_valid_o` out 1, `tkbr_o` out 1, `next_pc_o` out WIDTH: registered resolution.
- `redirect_valid_o` out 1, `redirect_pc_o` out WIDTH, `redirect_ready_i` in 1: redirect handshake.
- `lookup_pc_i` in WIDTH, `lookup_taken_o` out 1: BHT prediction read.
- `br_count_o`, `mispred_count_o` out 32: performance counters.

## Operation
- Accept when `valid_i && ready_o && !flush_i`. `ready_o = !redirect_valid_o`.
- Condition: signed compares for BEQ/BNE/BLT/BGE, unsigned for BLTU/BGEU; JAL/JALR are always taken.
- Target: JALR → `(br_src_a_i + imm_i) & ~1`; all others → `pc_i + imm_i`. Arithmetic is modulo 2^WIDTH.
- `next_pc = taken ? target : pc_i + 4`.
- Mispredict when `pred_taken_i != taken`, or when `taken && pred_target_i != target`.
- On accept, register `res_valid_o=1`, `tkbr_o`, `next_pc_o`. Set `redirect_valid_o` and `redirect_pc_o=next_pc` on mispredict. Increment `br_count_o`; increment `mispred_count_o` on mispredict. Both counters wrap at 2^32.
- `redirect_valid_o` and `redirect_pc_o` hold stable until `redirect_ready_i`; they clear on the cycle after the handshake.
- BHT: index = `pc[IDX_LSB +: $clog2(BHT_ENTRIES)]`. Only conditional branches train the table: taken → +1, saturating at 3; not-taken → −1, saturating at 0. JAL and JALR do not train.
- `lookup_taken_o = bht[idx(lookup_pc_i)][1]`, combinational.
- Read/write on the same index in the same cycle returns the old value.

## Timing
- Resolution latency is 1 cycle: `res_valid_o` is a single-cycle pulse the cycle after accept.
- A redirect is visible the same cycle as `res_valid_o` and blocks new accepts until the handshake. Back-to-back accepts are allowed when there is no mispredict.
- `flush_i` has priority over everything:
  - drops the input;
  - clears `res_valid_o` next cycle;
  - clears a pending redirect next cycle, even if `redirect_ready_i` is asserted;
  - does not train the BHT and does not count.
- Reset values: `res_valid_o=0`, `tkbr_o=0`, `next_pc_o=0`, `redirect_valid_o=0`, `redirect_pc_o=0`, both counters 0, all BHT counters `2'b01` (weakly not-taken), so `lookup_taken_o=0`.
- Reset asserted mid-redirect clears the redirect immediately (asynchronously).

## Structure
- `segre_pkg` gains `BHT_ENTRIES_DEFAULT` and `bht_ctr_t` (`logic [1:0]`).
- It also gains `br_result_t`, a struct of `{taken, next_pc, mispred}`.
- `alu_opcode_e` is reused unchanged.
- One sub-module, `segre_bht`: counter array with a write port (update enable, index, taken) and one combinational read port. Condition evaluation stays inline.

## Test plan
- BLT, src_a=0xFFFF_FFFF, src_b=1, pc=0x100, imm=0x20, pred not-taken → `tkbr_o=1`, `next_pc_o=0x120`, redirect to 0x120, `mispred_count_o=1`.
- BLTU with the same operands, pred not-taken → `tkbr_o=0`, `next_pc_o=0x104`, no redirect.
- JALR, src_a=0x203, imm=4, pred taken with target 0x206 → `next_pc_o=0x206`, no redirect. The same case with pred target 0x208 → redirect to 0x206.
- Mispredict with `redirect_ready_i` held low for 3 cycles → `ready_o=0` and redirect stable for 4 cycles, clearing the cycle after ready. Repeat with `flush_i` in cycle 2 → redirect clears, no handshake needed.
- BEQ at pc=0x40 taken 3 times → `lookup_taken_o(0x40)` reads 0 (counter 01), then 1 (counter 10), then 1 (counter 11). Four not-taken resolutions afterwards saturate the counter at 0.
- Reset asserted during a pending redirect → all outputs reach reset values without a clock edge, and `lookup_taken_o=0` for any PC.
